gcd_bist: RTL

GCD_BIST -- requirements
Module: gcd_bist

---
 rtl/gcd_bist_pkg.sv | 18 +
 rtl/gcd_bist.sv | 137 +++++++++++++
 2 files changed

// File: rtl/gcd_bist_pkg.sv
// Shared definitions for the GCD built-in self-test sequencer:
// state encoding and default run parameters.
package gcd_bist_pkg;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_NTESTS  = 8;
    localparam int DEF_TIMEOUT = 255;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        RUN,
        CHECK,
        DONE
    } state_t;

endpackage

// File: rtl/gcd_bist.sv
// BIST sequencer: walks an external registered vector ROM, drives a GCD core
// per vector, bounds each run by TIMEOUT and accumulates pass/fail status.
module gcd_bist
    import gcd_bist_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int NTESTS  = DEF_NTESTS,
    parameter int TIMEOUT = DEF_TIMEOUT,
    localparam int IW     = (NTESTS > 1) ? $clog2(NTESTS) : 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             go,
    output logic [IW-1:0]    vec_addr,
    input  logic [WIDTH-1:0] vec_a,
    input  logic [WIDTH-1:0] vec_b,
    input  logic [WIDTH-1:0] vec_y,
    output logic             core_reset,
    output logic             core_start,
    output logic [WIDTH-1:0] core_a,
    output logic [WIDTH-1:0] core_b,
    input  logic [WIDTH-1:0] core_outp,
    input  logic             core_done,
    output logic             busy,
    output logic             finished,
    output logic             passed,
    output logic [IW:0]      fail_count,
    output logic [IW-1:0]    first_fail,
    output logic [7:0]       last_cycles
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0] LAST = IW'(NTESTS - 1);

    state_t          state, state_next;
    logic [IW-1:0]   index;
    logic [CW-1:0]   cnt, cnt_next;
    logic [WIDTH-1:0] y_ref;
    logic            timed_out;
    logic            run_exit;
    logic            fail;
    logic [7:0]      cnt_sat;

    assign vec_addr = index;
    assign cnt_next = cnt + 1'b1;
    // completion wins over timeout when both land in the same RUN cycle
    assign run_exit = core_done || (cnt_next == CW'(TIMEOUT));
    assign fail     = timed_out || (core_outp != y_ref);

    always_comb begin
        cnt_sat = 8'(cnt);
        if (32'(cnt) > 32'd255) cnt_sat = 8'hFF;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        core_reset = 1'b0;
        core_start = 1'b0;
        case (state)
            IDLE, DONE: begin
                core_reset = 1'b1;
                if (go) state_next = FETCH;
            end
            FETCH: begin
                busy       = 1'b1;
                state_next = LOAD;
            end
            LOAD: begin
                busy       = 1'b1;
                core_reset = 1'b1;
                state_next = RUN;
            end
            RUN: begin
                busy       = 1'b1;
                core_start = 1'b1;
                if (run_exit) state_next = CHECK;
            end
            CHECK: begin
                busy       = 1'b1;
                state_next = (index == LAST) ? DONE : FETCH;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            index       <= '0;
            cnt         <= '0;
            core_a      <= '0;
            core_b      <= '0;
            y_ref       <= '0;
            timed_out   <= 1'b0;
            finished    <= 1'b0;
            passed      <= 1'b0;
            fail_count  <= '0;
            first_fail  <= '0;
            last_cycles <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE, DONE: begin
                    if (go) begin
                        fail_count <= '0;
                        passed     <= 1'b1;
                        finished   <= 1'b0;
                        index      <= '0;
                    end
                end
                LOAD: begin
                    core_a <= vec_a;
                    core_b <= vec_b;
                    y_ref  <= vec_y;
                    cnt    <= '0;
                end
                RUN: begin
                    cnt       <= cnt_next;
                    timed_out <= !core_done;
                end
                CHECK: begin
                    last_cycles <= cnt_sat;
                    if (fail) begin
                        fail_count <= fail_count + 1'b1;
                        passed     <= 1'b0;
                        if (fail_count == '0) first_fail <= index;
                    end
                    if (index == LAST) finished <= 1'b1;
                    else               index    <= index + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
